// File: rtl/cmos_gray_capture.sv
// cmos_gray_capture: discards the first frames of an 8-bit grey CMOS stream, re-times the
// stream onto frame-aligned post_* outputs, counts output frames and checks their geometry.
module cmos_gray_capture #(
    parameter bit          CMOS_VSYNC_VALID   = 1'b1,
    parameter int unsigned CMOS_FRAME_WAITCNT = 4,
    parameter int unsigned IMG_HDISP          = 640,
    parameter int unsigned IMG_VDISP          = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmos_vsync,
    input  logic       cmos_href,
    input  logic [7:0] cmos_data,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic [7:0] post_img_Y,
    output logic       frame_ready,
    output logic [7:0] frame_cnt,
    output logic       frame_done,
    output logic       size_err
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 11;
    localparam int unsigned WAIT_W = 8;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  HDISP     = CNT_W'(IMG_HDISP);
    localparam logic [CNT_W-1:0]  VDISP     = CNT_W'(IMG_VDISP);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CMOS_FRAME_WAITCNT - 1);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam state_t ST_INIT = (CMOS_FRAME_WAITCNT == 0) ? ST_ARMED : ST_WAIT;

    logic              vs_n;
    logic              vs_r1;
    logic              vs_r2;
    logic              href_r1;
    logic              href_r2;
    logic [DATA_W-1:0] data_r1;
    logic [1:0]        prime;
    logic              frame_start;
    logic              frame_end;
    logic              line_end;
    logic              frame_open;
    logic              gate;
    logic              run_end;
    logic              pix_valid;
    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  hcnt;
    logic [CNT_W-1:0]  vcnt;
    logic [CNT_W-1:0]  vcnt_next;
    logic              line_bad;
    logic              line_bad_next;

    assign vs_n = CMOS_VSYNC_VALID ? cmos_vsync : ~cmos_vsync;

    // Input stage; prime marks when vs_r2 holds a real sample, so a vsync already high at
    // reset release is never mistaken for a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_r1   <= 1'b0;
            vs_r2   <= 1'b0;
            href_r1 <= 1'b0;
            href_r2 <= 1'b0;
            data_r1 <= '0;
            prime   <= '0;
        end else begin
            vs_r1   <= vs_n;
            vs_r2   <= vs_r1;
            href_r1 <= cmos_href;
            href_r2 <= href_r1;
            data_r1 <= cmos_data;
            prime   <= {prime[0], 1'b1};
        end
    end

    assign frame_start = vs_r1 & ~vs_r2 & prime[1];
    assign frame_end   = ~vs_r1 & vs_r2;
    assign line_end    = href_r2 & ~href_r1 & vs_r2;

    // Only frames whose start was seen count as complete discarded frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_open <= 1'b0;
        end else if (frame_start) begin
            frame_open <= 1'b1;
        end else if (frame_end) begin
            frame_open <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT:  if (frame_end && frame_open && wait_cnt == WAIT_LAST) state_next = ST_ARMED;
            ST_ARMED: if (frame_start) state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
            default:  state_next = ST_INIT;
        endcase
    end

    always_comb begin
        gate    = 1'b0;
        run_end = 1'b0;
        case (state)
            ST_ARMED: gate = frame_start;
            ST_RUN: begin
                gate    = 1'b1;
                run_end = frame_end;
            end
            default: ;
        endcase
    end

    assign pix_valid = gate & vs_r1 & href_r1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT && frame_end && frame_open) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Geometry check; a line ending on frame_end is folded in through the next-state values.
    always_comb begin
        vcnt_next     = vcnt;
        line_bad_next = line_bad;
        if (frame_start) begin
            vcnt_next     = '0;
            line_bad_next = 1'b0;
        end else if (line_end) begin
            if (vcnt != CNT_MAX) vcnt_next = vcnt + CNT_W'(1);
            if (hcnt != HDISP) line_bad_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt     <= '0;
            vcnt     <= '0;
            line_bad <= 1'b0;
        end else begin
            if (href_r1) begin
                if (hcnt != CNT_MAX) hcnt <= hcnt + CNT_W'(1);
            end else if (href_r2) begin
                hcnt <= '0;
            end
            vcnt     <= vcnt_next;
            line_bad <= line_bad_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_img_Y       <= '0;
            frame_ready      <= 1'b0;
            frame_cnt        <= '0;
            frame_done       <= 1'b0;
            size_err         <= 1'b0;
        end else begin
            post_frame_vsync <= gate & vs_r1;
            post_frame_href  <= pix_valid;
            post_img_Y       <= pix_valid ? data_r1 : '0;
            frame_ready      <= (state_next == ST_RUN);
            frame_done       <= run_end;
            size_err         <= run_end & (line_bad_next | (vcnt_next != VDISP));
            if (run_end) frame_cnt <= frame_cnt + 8'(1);
        end
    end

endmodule

// File: tb/tb_cmos_gray_capture.sv
// Directed bench: two captures (high vsync / 4-frame wait, low vsync / no wait) share one
// camera stream; each output pixel is matched against the input pixel 2 clk earlier.
module tb_cmos_gray_capture;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       vs_act = 1'b0;
    logic       href   = 1'b0;
    logic [7:0] data   = 8'h00;
    logic       vs_hi;
    logic       vs_lo;

    logic       a_vs, a_hs, a_rdy, a_done, a_serr;
    logic [7:0] a_y, a_cnt;
    logic       b_vs, b_hs, b_rdy, b_done, b_serr;
    logic [7:0] b_y, b_cnt;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    int          frame_no = 0;

    logic [39:0] in_q[$];
    logic [39:0] qa[$];
    logic [39:0] qb[$];
    int qa_base, qb_base, in_base, da_base, db_base;
    int done_a = 0, done_b = 0, align_a = 0, align_b = 0, ybad_a = 0, ybad_b = 0;
    logic serr_a = 1'b0, serr_b = 1'b0, pa = 1'b0, pb = 1'b0;
    int unsigned rel_cyc;
    logic [7:0] exp_a = 8'd0;
    logic [7:0] exp_b = 8'd0;

    assign vs_hi = vs_act;
    assign vs_lo = ~vs_act;

    cmos_gray_capture #(
        .CMOS_VSYNC_VALID(1'b1), .CMOS_FRAME_WAITCNT(4), .IMG_HDISP(8), .IMG_VDISP(4)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .cmos_vsync(vs_hi), .cmos_href(href), .cmos_data(data),
        .post_frame_vsync(a_vs), .post_frame_href(a_hs), .post_img_Y(a_y),
        .frame_ready(a_rdy), .frame_cnt(a_cnt), .frame_done(a_done), .size_err(a_serr)
    );

    cmos_gray_capture #(
        .CMOS_VSYNC_VALID(1'b0), .CMOS_FRAME_WAITCNT(0), .IMG_HDISP(8), .IMG_VDISP(4)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .cmos_vsync(vs_lo), .cmos_href(href), .cmos_data(data),
        .post_frame_vsync(b_vs), .post_frame_href(b_hs), .post_img_Y(b_y),
        .frame_ready(b_rdy), .frame_cnt(b_cnt), .frame_done(b_done), .size_err(b_serr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Output monitor: records pixels, frame_done pulses and pulse/vsync alignment.
    always @(negedge clk) begin
        if (a_hs) qa.push_back({cyc, a_y});
        else if (a_y != 8'h00) ybad_a <= ybad_a + 1;
        if (b_hs) qb.push_back({cyc, b_y});
        else if (b_y != 8'h00) ybad_b <= ybad_b + 1;
        if (a_done) begin
            done_a <= done_a + 1;
            serr_a <= a_serr;
            if (!(pa && !a_vs)) align_a <= align_a + 1;
        end else if (a_serr) align_a <= align_a + 1;
        if (b_done) begin
            done_b <= done_b + 1;
            serr_b <= b_serr;
            if (!(pb && !b_vs)) align_b <= align_b + 1;
        end else if (b_serr) align_b <= align_b + 1;
        pa <= a_vs;
        pb <= b_vs;
    end

    function automatic bit pix_ok(input bit use_b);
        int n_out;
        logic [39:0] o;
        n_out = use_b ? qb.size() - qb_base : qa.size() - qa_base;
        if (n_out != in_q.size() - in_base) return 1'b0;
        for (int i = 0; i < n_out; i++) begin
            o = use_b ? qb[qb_base + i] : qa[qa_base + i];
            if (o !== in_q[in_base + i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic send_frame(input int hd, input int vd, input bit do_rst);
        qa_base = qa.size(); qb_base = qb.size(); in_base = in_q.size();
        da_base = done_a;    db_base = done_b;
        frame_no++;
        vs_act = 1'b0; href = 1'b0; data = 8'h00;
        repeat (3) @(posedge clk);
        #1 vs_act = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int l = 0; l < vd; l++) begin
            for (int p = 0; p < hd; p++) begin
                href = 1'b1;
                data = 8'(frame_no * 3 + l * 16 + p);
                in_q.push_back({32'(cyc + 32'd2), data});
                if (do_rst && l == 1 && p == 2) begin
                    rst_n = 1'b0;
                    #1;
                    checks++;
                    if ({a_vs, a_hs, a_y, a_rdy, a_cnt, a_done, a_serr} !== 21'h0) begin
                        errors++;
                        $display("FAIL async_reset_a: got %0h expected 0",
                                 {a_vs, a_hs, a_y, a_rdy, a_cnt, a_done, a_serr});
                    end
                    checks++;
                    if ({b_vs, b_hs, b_y, b_rdy, b_cnt, b_done, b_serr} !== 21'h0) begin
                        errors++;
                        $display("FAIL async_reset_b: got %0h expected 0",
                                 {b_vs, b_hs, b_y, b_rdy, b_cnt, b_done, b_serr});
                    end
                end
                if (do_rst && l == 1 && p == 5) begin
                    rst_n   = 1'b1;
                    rel_cyc = cyc;
                end
                @(posedge clk);
                #1;
            end
            href = 1'b0; data = 8'h00;
            repeat (3) @(posedge clk);
            #1;
        end
        vs_act = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        vs_act = 1'b1; href = 1'b1; data = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_vs, a_hs, a_y, a_rdy, a_cnt, a_done, a_serr} !== 21'h0) begin
            errors++;
            $display("FAIL reset_a: got %0h expected 0", {a_vs, a_hs, a_y, a_rdy, a_cnt, a_done, a_serr});
        end
        checks++;
        if ({b_vs, b_hs, b_y, b_rdy, b_cnt, b_done, b_serr} !== 21'h0) begin
            errors++;
            $display("FAIL reset_b: got %0h expected 0", {b_vs, b_hs, b_y, b_rdy, b_cnt, b_done, b_serr});
        end
        vs_act = 1'b0; href = 1'b0; data = 8'h00;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_wait_frames();
        for (int f = 0; f < 4; f++) begin
            send_frame(8, 4, 1'b0);
            exp_b = exp_b + 8'd1;
            checks++;
            if (qa.size() - qa_base != 0 || a_rdy !== 1'b0 || a_cnt !== 8'd0 || done_a != da_base) begin
                errors++;
                $display("FAIL wait_discard f%0d: pix=%0d rdy=%b cnt=%0d done=%0d expected 0", f,
                         qa.size() - qa_base, a_rdy, a_cnt, done_a - da_base);
            end
            checks++;
            if (!pix_ok(1'b1) || b_cnt !== exp_b || serr_b !== 1'b0) begin
                errors++;
                $display("FAIL lowpol_frame f%0d: pix=%0d cnt=%0d serr=%b expected 32/%0d/0", f,
                         qb.size() - qb_base, b_cnt, serr_b, exp_b);
            end
        end
    endtask

    task automatic test_first_frame();
        send_frame(8, 4, 1'b0);
        exp_a = exp_a + 8'd1;
        exp_b = exp_b + 8'd1;
        checks++;
        if (qa.size() - qa_base != 32) begin
            errors++;
            $display("FAIL first_pix_count: got %0d expected 32", qa.size() - qa_base);
        end
        checks++;
        if (!pix_ok(1'b0)) begin
            errors++;
            $display("FAIL first_pix_data: got mismatch expected data delayed 2 clk");
        end
        checks++;
        if (a_cnt !== 8'd1 || done_a - da_base != 1 || serr_a !== 1'b0 || a_rdy !== 1'b1) begin
            errors++;
            $display("FAIL first_frame_status: cnt=%0d done=%0d serr=%b rdy=%b expected 1/1/0/1",
                     a_cnt, done_a - da_base, serr_a, a_rdy);
        end
        checks++;
        if (!pix_ok(1'b1) || b_cnt !== exp_b) begin
            errors++;
            $display("FAIL polarity_match: cnt=%0d expected %0d with identical pixels", b_cnt, exp_b);
        end
        checks++;
        if (align_a + align_b + ybad_a + ybad_b != 0) begin
            errors++;
            $display("FAIL done_align_idle: got %0d expected 0", align_a + align_b + ybad_a + ybad_b);
        end
    endtask

    task automatic test_size_err();
        int hd_t[3] = '{7, 8, 8};
        int vd_t[3] = '{4, 3, 4};
        logic se_t[3] = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            send_frame(hd_t[k], vd_t[k], 1'b0);
            exp_a = exp_a + 8'd1;
            exp_b = exp_b + 8'd1;
            checks++;
            if (done_a - da_base != 1 || serr_a !== se_t[k] || a_cnt !== exp_a) begin
                errors++;
                $display("FAIL size_err_a %0dx%0d: done=%0d serr=%b cnt=%0d expected 1/%b/%0d",
                         hd_t[k], vd_t[k], done_a - da_base, serr_a, a_cnt, se_t[k], exp_a);
            end
            checks++;
            if (done_b - db_base != 1 || serr_b !== se_t[k] || !pix_ok(1'b1)) begin
                errors++;
                $display("FAIL size_err_b %0dx%0d: done=%0d serr=%b expected 1/%b",
                         hd_t[k], vd_t[k], done_b - db_base, serr_b, se_t[k]);
            end
        end
    endtask

    task automatic test_wrap();
        for (int f = 0; f < 252; f++) begin
            send_frame(8, 4, 1'b0);
            exp_a = exp_a + 8'd1;
            exp_b = exp_b + 8'd1;
            checks++;
            if (b_cnt !== exp_b || a_cnt !== exp_a || b_rdy !== 1'b1 || a_rdy !== 1'b1) begin
                errors++;
                $display("FAIL wrap_cnt f%0d: a=%0d b=%0d rdy=%b%b expected %0d/%0d/11",
                         f, a_cnt, b_cnt, a_rdy, b_rdy, exp_a, exp_b);
            end
        end
        checks++;
        if (b_cnt !== 8'd4) begin
            errors++;
            $display("FAIL wrap_final: got %0d expected 4", b_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        int late;
        send_frame(8, 4, 1'b1);
        late = 0;
        for (int i = qa_base; i < qa.size(); i++) if (qa[i][39:8] >= rel_cyc) late++;
        for (int i = qb_base; i < qb.size(); i++) if (qb[i][39:8] >= rel_cyc) late++;
        checks++;
        if (late != 0 || done_a != da_base || done_b != db_base || a_cnt !== 8'd0 || b_cnt !== 8'd0) begin
            errors++;
            $display("FAIL partial_frame: late_pix=%0d done=%0d/%0d cnt=%0d/%0d expected 0",
                     late, done_a - da_base, done_b - db_base, a_cnt, b_cnt);
        end
        for (int f = 0; f < 4; f++) begin
            send_frame(8, 4, 1'b0);
            checks++;
            if (qa.size() - qa_base != 0 || a_rdy !== 1'b0) begin
                errors++;
                $display("FAIL rewait_discard f%0d: pix=%0d rdy=%b expected 0/0", f, qa.size() - qa_base, a_rdy);
            end
            if (f == 0) begin
                checks++;
                if (!pix_ok(1'b1) || b_cnt !== 8'd1 || serr_b !== 1'b0 || done_b - db_base != 1) begin
                    errors++;
                    $display("FAIL restart_b: cnt=%0d serr=%b done=%0d expected 1/0/1",
                             b_cnt, serr_b, done_b - db_base);
                end
            end
        end
        send_frame(8, 4, 1'b0);
        checks++;
        if (!pix_ok(1'b0) || a_cnt !== 8'd1 || serr_a !== 1'b0) begin
            errors++;
            $display("FAIL restart_a: pix=%0d cnt=%0d serr=%b expected 32/1/0",
                     qa.size() - qa_base, a_cnt, serr_a);
        end
    endtask

    initial begin
        test_reset();
        test_wait_frames();
        test_first_frame();
        test_size_err();
        test_wrap();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
